// File: rtl/bitwise_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_unit
//  Description : Per-bit logic unit (NOT/AND/OR/XOR and their complements,
//                pass-through) with a valid/ready input side and a 2-entry
//                in-order output buffer. Result flags: zero and sign.
//                Optional macro BITWISE_UNIT_STATS_EN adds a 16-bit wrapping
//                count of completed output transfers (xfer_count port).
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng
`ifdef BITWISE_UNIT_STATS_EN
    ,
    output logic [15:0]      xfer_count
`endif
);

    // Buffer occupancy; the head entry lives directly in the output registers.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             r_state;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_result;
    logic             w_push;
    logic             w_pop;

    // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Per-bit operation select; no carries between bit positions.
    always_comb begin
        w_result = a;
        case (op)
            3'b000:  w_result = ~a;
            3'b001:  w_result = a & b;
            3'b010:  w_result = a | b;
            3'b011:  w_result = a ^ b;
            3'b100:  w_result = ~(a & b);
            3'b101:  w_result = ~(a | b);
            3'b110:  w_result = ~(a ^ b);
            default: w_result = a;
        endcase
    end

    // Occupancy FSM; head data, flags, ready and valid are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_tail    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zr    <= 1'b1;
            out_ng    <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        out_data  <= w_result;
                        out_zr    <= (w_result == '0);
                        out_ng    <= w_result[WIDTH-1];
                        out_valid <= 1'b1;
                        r_state   <= ONE;
                    end
                end
                ONE: begin
                    case ({w_push, w_pop})
                        2'b10: begin
                            // Head is still waiting: new result queues behind it.
                            r_tail   <= w_result;
                            in_ready <= 1'b0;
                            r_state  <= FULL;
                        end
                        2'b11: begin
                            // Head leaves while the new result takes its place.
                            out_data <= w_result;
                            out_zr   <= (w_result == '0);
                            out_ng   <= w_result[WIDTH-1];
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            r_state   <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // No push is possible here; a pop promotes the tail.
                    if (w_pop) begin
                        out_data <= r_tail;
                        out_zr   <= (r_tail == '0);
                        out_ng   <= r_tail[WIDTH-1];
                        in_ready <= 1'b1;
                        r_state  <= ONE;
                    end
                end
                default: begin
                    r_state   <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BITWISE_UNIT_STATS_EN
    // Count completed output transfers, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= 16'h0000;
        end else if (w_pop) begin
            xfer_count <= xfer_count + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitwise_unit
//  Description : Directed self-checking bench for bitwise_unit (WIDTH=16).
//                Stats checks compile in when BITWISE_UNIT_STATS_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zr;
    logic             out_ng;
`ifdef BITWISE_UNIT_STATS_EN
    logic [15:0]      xfer_count;
`endif

    int total;
    int bad;

    bitwise_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng)
`ifdef BITWISE_UNIT_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic zr, input logic ng);
        check_value({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check_value({tag, ".data"},  {16'd0, out_data},  {16'd0, d});
        check_value({tag, ".zr"},    {31'd0, out_zr},    {31'd0, zr});
        check_value({tag, ".ng"},    {31'd0, out_ng},    {31'd0, ng});
    endtask

    logic [15:0] sweep_exp [8];

    initial begin
        total = 0;
        bad   = 0;
        sweep_exp[0] = 16'hFF00; sweep_exp[1] = 16'h000F;
        sweep_exp[2] = 16'h0FFF; sweep_exp[3] = 16'h0FF0;
        sweep_exp[4] = 16'hFFF0; sweep_exp[5] = 16'hF000;
        sweep_exp[6] = 16'hF00F; sweep_exp[7] = 16'h00FF;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = '0; b = '0;
        #12;
        // Reset state
        check_value("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_out("rst", 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef BITWISE_UNIT_STATS_EN
        check_value("rst.xfer", {16'd0, xfer_count}, 32'd0);
`endif
        rst_n = 1'b1;
        #2;

        // First op after release: NOT of zero, latency 1
        in_valid = 1'b1; out_ready = 1'b1; op = 3'b000; a = 16'h0000; b = 16'h0000;
        step();
        check_out("not0", 1'b1, 16'hFFFF, 1'b0, 1'b1);

        // Sweep all ops back-to-back while draining each cycle
        a = 16'h00FF; b = 16'h0F0F;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            check_out($sformatf("sweep%0d", i), 1'b1, sweep_exp[i], sweep_exp[i] == 16'h0, sweep_exp[i][15]);
        end

        // AND of disjoint masks gives zero
        op = 3'b001; a = 16'hFF00; b = 16'h00FF;
        step();
        check_out("and_zero", 1'b1, 16'h0000, 1'b1, 1'b0);

        // Drain
        in_valid = 1'b0;
        step();
        check_value("drain.valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: three pushes with out_ready low
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h00FF; b = 16'h0F0F;
        op = 3'b001;
        step();
        check_out("bp1", 1'b1, 16'h000F, 1'b0, 1'b0);
        check_value("bp1.in_ready", {31'd0, in_ready}, 32'd1);
        op = 3'b010;
        step();
        check_out("bp2", 1'b1, 16'h000F, 1'b0, 1'b0);
        check_value("bp2.in_ready", {31'd0, in_ready}, 32'd0);
        op = 3'b011;
        step();
        check_out("bp3_held", 1'b1, 16'h000F, 1'b0, 1'b0);
        check_value("bp3.in_ready", {31'd0, in_ready}, 32'd0);
        // Operand changes without a handshake must not disturb anything
        a = 16'hAAAA; b = 16'h5555; op = 3'b000;
        step();
        check_out("bp_ignore", 1'b1, 16'h000F, 1'b0, 1'b0);
        a = 16'h00FF; b = 16'h0F0F; op = 3'b011;

        // FULL with in_valid and out_ready: pop only
        out_ready = 1'b1;
        step();
        check_out("full_pop", 1'b1, 16'h0FFF, 1'b0, 1'b0);
        check_value("full_pop.in_ready", {31'd0, in_ready}, 32'd1);
        // Next cycle the held op is pushed while second result pops
        step();
        check_out("push_after", 1'b1, 16'h0FF0, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        check_value("bp_drained", {31'd0, out_valid}, 32'd0);

        // Reset mid-cycle with two buffered results
        out_ready = 1'b0; in_valid = 1'b1;
        op = 3'b111; a = 16'h1234;
        step();
        op = 3'b000; a = 16'h1234;
        step();
        in_valid = 1'b0;
        check_out("pre_rst", 1'b1, 16'h1234, 1'b0, 1'b0);
        check_value("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 16'h0000, 1'b1, 1'b0);
        check_value("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value($sformatf("post_rst%0d.valid", i), {31'd0, out_valid}, 32'd0);
        end

        // Input accepted on the first edge after release
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1; in_valid = 1'b1; op = 3'b011; a = 16'h8001; b = 16'h0001;
        step();
        check_out("first_edge", 1'b1, 16'h8000, 1'b0, 1'b1);
        in_valid = 1'b0;
        step();

`ifdef BITWISE_UNIT_STATS_EN
        // 65537 transfers wrap the counter to 1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'b111; a = 16'h0001;
        step();
        check_value("stats.first", {16'd0, xfer_count}, 32'd0);
        for (int i = 0; i < 65537; i++) step();
        check_value("stats.wrap", {16'd0, xfer_count}, 32'd1);
        in_valid = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bitwise_unit.md
BITWISE_UNIT -- requirements
Module: bitwise_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, data width in bits (WIDTH >= 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream has an operation.
REQ-005 SHALL have port: in_ready  output  1  block accepts an operation this cycle.
REQ-006 SHALL have port: op  input  3  operation select; sampled with a and b.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port: out_data  output  WIDTH  result.
REQ-011 SHALL have port: out_zr  output  1  out_data == 0.
REQ-012 SHALL have port: out_ng  output  1  out_data[WIDTH-1].
REQ-013 SHALL have port: xfer_count  output  16  completed output transfers; present only with BITWISE_UNIT_STATS_EN.

Function
REQ-014 SHALL compute by op: 000 ~a; 001 a&b; 010 a|b; 011 a^b; 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 a.
REQ-015 SHALL compute every bit independently; no carries; result width WIDTH.
REQ-016 SHALL accept an input when in_valid && in_ready at a rising edge.
REQ-017 SHALL store results in a 2-entry in-order output buffer; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-018 SHALL drive in_ready = (occupancy != FULL), from registered state only; no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (occupancy != EMPTY); out_data, out_zr and out_ng reflect the head entry.
REQ-020 SHALL present an accepted result on out_valid in the next cycle when the buffer was EMPTY (latency 1).
REQ-021 SHALL pop the head when out_valid && out_ready at a rising edge.
REQ-022 SHALL keep out_data, out_zr and out_ng stable while out_valid && !out_ready.
REQ-023 Transitions: push only: EMPTY->ONE, ONE->FULL; pop only: FULL->ONE, ONE->EMPTY; push and pop: occupancy unchanged, order preserved.
REQ-024 SHALL not accept input in FULL even when out_ready is high; the pop frees the slot for the next cycle.
REQ-025 SHALL not drop or duplicate a result; results leave in acceptance order.
REQ-026 SHALL ignore op, a and b when no input handshake occurs.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear occupancy to EMPTY: out_valid=0, in_ready=1, out_data=0, out_zr=1, out_ng=0, xfer_count=0.
REQ-028 Reset mid-operation SHALL discard all buffered results; none appear after release.
REQ-029 SHALL accept input on the first rising edge after rst_n goes high.

Configuration
REQ-030 With BITWISE_UNIT_STATS_EN defined: xfer_count SHALL increment by 1 on each output handshake and wrap 0xFFFF->0x0000.
REQ-031 Without BITWISE_UNIT_STATS_EN: xfer_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then op=000, a=16'h0000, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=16'hFFFF, out_zr=0, out_ng=1.
REQ-033 Sweep all 8 ops with a=16'h00FF, b=16'h0F0F -> 0xFF00, 0x000F, 0x0FFF, 0x0FF0, 0xFFF0, 0xF000, 0xF00F, 0x00FF; op=001 with a=16'hFF00, b=16'h00FF -> 0x0000, out_zr=1.
REQ-034 out_ready=0 while pushing three ops back-to-back -> in_ready=0 after the second push, the third is held; out_data holds the first result; releasing out_ready drains results in order.
REQ-035 In FULL with in_valid=1 and out_ready=1 -> pop occurs, no push that cycle; push occurs on the next cycle.
REQ-036 Two results buffered, then rst_n pulsed low mid-cycle -> out_valid=0 immediately; no result appears after release.
REQ-037 WIDTH=1 and WIDTH=32 builds pass REQ-033 patterns; with BITWISE_UNIT_STATS_EN, 65537 transfers -> xfer_count=1.
